// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the BRAM port arbiter and the BRAM wrapper it feeds.
package bram_arb_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } arb_state_e;

   // Port width modes understood by the BRAM techmap wrapper
   localparam logic [2:0] MODE_X1   = 3'd0;
   localparam logic [2:0] MODE_X2   = 3'd1;
   localparam logic [2:0] MODE_X4   = 3'd2;
   localparam logic [2:0] MODE_X9   = 3'd3;
   localparam logic [2:0] MODE_X18  = 3'd4;
   localparam logic [2:0] MODE_BAD  = 3'd7;

   function automatic logic [2:0] dbits_to_mode(input int dbits);
      case (dbits)
         1:       return MODE_X1;
         2:       return MODE_X2;
         4:       return MODE_X4;
         9:       return MODE_X9;
         18:      return MODE_X18;
         default: return MODE_BAD;
      endcase
   endfunction

   function automatic int tag_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Rotating-priority grant: first set request at or above ptr, wrapping around.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int TW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [TW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [TW-1:0]   gnt_idx
);

   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      // walk from the farthest offset down so the nearest request wins
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = TW'(idx);
         end
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port among NREQ requesters, with tagged read
// responses and a hardware zero-fill sequencer.
//
// state | meaning
// RUN   | arbitrate requests onto the BRAM port each cycle
// CLEAR | sweep addresses 0..DEPTH-1 writing zeros, requests held off
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ABITS  = 14,
   parameter int DBITS  = 18,
   parameter int BEBITS = 2,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic [NREQ-1:0]         REQ_VALID,
   output logic [NREQ-1:0]         REQ_READY,
   input  logic [NREQ-1:0]         REQ_WE,
   input  logic [NREQ*ABITS-1:0]   REQ_ADDR,
   input  logic [NREQ*DBITS-1:0]   REQ_WDATA,
   input  logic [NREQ*BEBITS-1:0]  REQ_BE,
   output logic [NREQ-1:0]         RSP_VALID,
   output logic [DBITS-1:0]        RSP_RDATA,
   input  logic                    CLR_START,
   output logic                    CLR_BUSY,
   output logic                    CLR_DONE,
   output logic [ABITS-1:0]        BRAM_ADDR,
   output logic [DBITS-1:0]        BRAM_WDATA,
   output logic                    BRAM_REN,
   output logic                    BRAM_WEN,
   output logic [BEBITS-1:0]       BRAM_BE,
   input  logic [DBITS-1:0]        BRAM_RDATA
);

   localparam int TW = tag_width(NREQ);
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (dbits_to_mode(DBITS) == MODE_BAD) begin : g_bad_dbits
      $error("bram_port_arbiter: unsupported DBITS");
   end
   if (DEPTH > (1 << ABITS)) begin : g_bad_depth
      $error("bram_port_arbiter: DEPTH exceeds address space");
   end

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [TW-1:0]     rr_ptr_q;
   logic [NREQ-1:0]   gnt;
   logic [TW-1:0]     gnt_idx;
   logic [CW-1:0]     clr_cnt_q;
   logic              clr_last;
   logic              clr_done_q;
   logic              grant_en;
   logic              rd_accept;
   logic [RD_LAT-1:0] tag_vld_q;
   logic [TW-1:0]     tag_idx_q [RD_LAT];

   rr_arbiter #(
      .NREQ (NREQ),
      .TW   (TW)
   ) u_rr_arbiter (
      .req     (REQ_VALID),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign clr_last  = (clr_cnt_q == CW'(DEPTH - 1));
   // a clear request pre-empts any grant in the cycle it arrives
   assign grant_en  = (state_q == RUN) && !CLR_START && (|REQ_VALID);
   assign rd_accept = grant_en && !REQ_WE[gnt_idx];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (CLR_START) state_d = CLEAR;
         CLEAR:   if (clr_last)  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      REQ_READY  = '0;
      BRAM_ADDR  = '0;
      BRAM_WDATA = '0;
      BRAM_REN   = 1'b0;
      BRAM_WEN   = 1'b0;
      BRAM_BE    = '0;
      case (state_q)
         CLEAR: begin
            BRAM_WEN  = 1'b1;
            BRAM_BE   = '1;
            BRAM_ADDR = ABITS'(clr_cnt_q);
         end
         default: begin
            if (grant_en) begin
               REQ_READY = gnt;
               BRAM_ADDR = REQ_ADDR[gnt_idx*ABITS +: ABITS];
               if (REQ_WE[gnt_idx]) begin
                  BRAM_WEN   = 1'b1;
                  BRAM_BE    = REQ_BE[gnt_idx*BEBITS +: BEBITS];
                  BRAM_WDATA = REQ_WDATA[gnt_idx*DBITS +: DBITS];
               end else begin
                  BRAM_REN = 1'b1;
               end
            end
         end
      endcase
   end

   assign CLR_BUSY = (state_q == CLEAR);
   assign CLR_DONE = clr_done_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rr_ptr_q <= '0;
      end else if (grant_en) begin
         rr_ptr_q <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         clr_cnt_q  <= '0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= (state_q == CLEAR) && clr_last;
         if (state_q == RUN) begin
            if (CLR_START) begin
               clr_cnt_q <= '0;
            end
         end else begin
            clr_cnt_q <= clr_last ? '0 : clr_cnt_q + 1'b1;
         end
      end
   end

   // tag pipeline mirrors the BRAM read latency; clear does not flush it
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tag_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_idx_q[i] <= '0;
         end
      end else begin
         tag_vld_q[0] <= rd_accept;
         tag_idx_q[0] <= gnt_idx;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end

   always_comb begin
      RSP_VALID = '0;
      RSP_RDATA = '0;
      if (tag_vld_q[RD_LAT-1]) begin
         RSP_VALID[tag_idx_q[RD_LAT-1]] = 1'b1;
         RSP_RDATA = BRAM_RDATA;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: handshake, round-robin, clear and reset behaviour.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  req_we;
   logic [55:0] req_addr;
   logic [71:0] req_wdata;
   logic [7:0]  req_be;
   logic [3:0]  rsp_valid;
   logic [17:0] rsp_rdata;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic [13:0] bram_addr;
   logic [17:0] bram_wdata;
   logic        bram_ren;
   logic        bram_wen;
   logic [1:0]  bram_be;
   logic [17:0] bram_rdata;
   logic [17:0] bram_rd_q;
   logic [17:0] mem [0:16383];

   logic        rst2_n;
   logic [3:0]  req_valid2;
   logic [3:0]  req_ready2;
   logic [3:0]  rsp_valid2;
   logic [17:0] rsp_rdata2;
   logic        clr_busy2;
   logic        clr_done2;
   logic [13:0] bram_addr2;
   logic [17:0] bram_wdata2;
   logic        bram_ren2;
   logic        bram_wen2;
   logic [1:0]  bram_be2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .NREQ(4), .ABITS(14), .DBITS(18), .BEBITS(2), .DEPTH(1024), .RD_LAT(1)
   ) u_dut (
      .CLK(clk), .RESET_N(rst_n),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE(req_be),
      .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
      .CLR_START(clr_start), .CLR_BUSY(clr_busy), .CLR_DONE(clr_done),
      .BRAM_ADDR(bram_addr), .BRAM_WDATA(bram_wdata), .BRAM_REN(bram_ren),
      .BRAM_WEN(bram_wen), .BRAM_BE(bram_be), .BRAM_RDATA(bram_rdata)
   );

   bram_port_arbiter #(
      .NREQ(4), .ABITS(14), .DBITS(18), .BEBITS(2), .DEPTH(1024), .RD_LAT(2)
   ) u_dut_lat2 (
      .CLK(clk), .RESET_N(rst2_n),
      .REQ_VALID(req_valid2), .REQ_READY(req_ready2), .REQ_WE(4'b0000),
      .REQ_ADDR(56'd0), .REQ_WDATA(72'd0), .REQ_BE(8'd0),
      .RSP_VALID(rsp_valid2), .RSP_RDATA(rsp_rdata2),
      .CLR_START(1'b0), .CLR_BUSY(clr_busy2), .CLR_DONE(clr_done2),
      .BRAM_ADDR(bram_addr2), .BRAM_WDATA(bram_wdata2), .BRAM_REN(bram_ren2),
      .BRAM_WEN(bram_wen2), .BRAM_BE(bram_be2), .BRAM_RDATA(18'h00155)
   );

   function automatic logic [17:0] init_word(input int a);
      return 18'(a * 1237 + 99);
   endfunction

   // one-cycle-latency BRAM with 9-bit byte lanes
   always @(posedge clk) begin
      if (bram_wen) begin
         if (bram_be[0]) mem[bram_addr][8:0]  <= bram_wdata[8:0];
         if (bram_be[1]) mem[bram_addr][17:9] <= bram_wdata[17:9];
      end
      if (bram_ren) bram_rd_q <= mem[bram_addr];
   end
   assign bram_rdata = bram_rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [13:0] a,
                          input logic [17:0] d, input logic [1:0] be);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*14 +: 14]  = a;
      req_wdata[i*18 +: 18] = d;
      req_be[i*2 +: 2]      = be;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int busy_n;
      int done_n;
      for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
      rst_n      = 1'b0;
      rst2_n     = 1'b0;
      clr_start  = 1'b0;
      req_valid2 = '0;
      clear_reqs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready",  32'(req_ready), 'h0);
      check("rst_bram",   32'({bram_ren, bram_wen}), 'h0);
      check("rst_rsp",    32'(rsp_valid), 'h0);
      check("rst_clr",    32'({clr_busy, clr_done}), 'h0);
      next_cyc();
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      // requester 1 write then read back
      set_req(1, 1'b1, 14'd5, 18'h2A5A5, 2'b11);
      @(negedge clk);
      check("t1_wr_ready", 32'(req_ready), 'h2);
      check("t1_wr_wen",   32'({bram_wen, bram_ren}), 'h2);
      check("t1_wr_addr",  32'(bram_addr), 'd5);
      check("t1_wr_data",  32'(bram_wdata), 'h2A5A5);
      check("t1_wr_be",    32'(bram_be), 'h3);
      next_cyc();
      set_req(1, 1'b0, 14'd5, 18'h0, 2'b00);
      @(negedge clk);
      check("t1_rd_ready", 32'(req_ready), 'h2);
      check("t1_rd_ren",   32'({bram_wen, bram_ren}), 'h1);
      check("t1_rd_norsp", 32'(rsp_valid), 'h0);
      next_cyc();
      clear_reqs();
      @(negedge clk);
      check("t1_rsp_vld",  32'(rsp_valid), 'h2);
      check("t1_rsp_data", 32'(rsp_rdata), 'h2A5A5);
      check("t1_idle_bram", 32'({bram_addr, bram_wen, bram_ren}), 'h0);

      // pointer is 2: requesters 0 and 3 compete, 3 wins first
      next_cyc();
      set_req(0, 1'b0, 14'd10, 18'h0, 2'b00);
      set_req(3, 1'b0, 14'd13, 18'h0, 2'b00);
      @(negedge clk);
      check("t3_gnt3", 32'(req_ready), 'h8);
      check("t3_addr13", 32'(bram_addr), 'd13);
      next_cyc();
      req_valid[3] = 1'b0;
      @(negedge clk);
      check("t3_gnt0", 32'(req_ready), 'h1);
      check("t3_rsp3", 32'(rsp_valid), 'h8);
      check("t3_rsp3_data", 32'(rsp_rdata), 32'(init_word(13)));
      next_cyc();
      clear_reqs();
      @(negedge clk);
      check("t3_rsp0", 32'(rsp_valid), 'h1);
      check("t3_rsp0_data", 32'(rsp_rdata), 32'(init_word(10)));
      next_cyc();
      set_req(3, 1'b1, 14'd100, 18'h1, 2'b11);
      @(negedge clk);
      check("t3_ptr1_gnt3", 32'(req_ready), 'h8);

      // pointer is 0: all four requesters continuously reading
      next_cyc();
      clear_reqs();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 14'(i), 18'h0, 2'b00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("t2_gnt%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
         check($sformatf("t2_addr%0d", k), 32'(bram_addr), 32'(k % 4));
         check($sformatf("t2_rsp%0d", k), 32'(rsp_valid),
               (k == 0) ? 32'h0 : 32'(1 << ((k - 1) % 4)));
         check($sformatf("t2_rdata%0d", k), 32'(rsp_rdata),
               (k == 0) ? 32'h0 : 32'(init_word((k - 1) % 4)));
         next_cyc();
      end
      clear_reqs();
      @(negedge clk);
      check("t2_rsp_last", 32'(rsp_valid), 'h1);
      check("t2_rdata_last", 32'(rsp_rdata), 32'(init_word(0)));

      // clear: write ones to 1023, then clear pre-empts a pending request
      next_cyc();
      set_req(2, 1'b1, 14'd1023, 18'h3FFFF, 2'b11);
      @(negedge clk);
      check("t4_wr_gnt2", 32'(req_ready), 'h4);
      next_cyc();
      clear_reqs();
      set_req(0, 1'b0, 14'd1023, 18'h0, 2'b00);
      clr_start = 1'b1;
      @(negedge clk);
      check("t4_start_nogrant", 32'(req_ready), 'h0);
      check("t4_start_nobram", 32'({bram_wen, bram_ren}), 'h0);
      check("t4_start_notbusy", 32'(clr_busy), 'h0);
      next_cyc();
      clr_start = 1'b0;
      bad = 0;
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < 1024; i++) begin
         if (i == 500) clr_start = 1'b1;
         @(negedge clk);
         if (clr_busy) busy_n++;
         if (clr_done) done_n++;
         if (!(bram_wen && !bram_ren && bram_be == 2'b11 && bram_addr == 14'(i) &&
               bram_wdata == 18'h0 && req_ready == 4'h0)) bad++;
         next_cyc();
         clr_start = 1'b0;
      end
      check("t4_busy_cycles", 32'(busy_n), 'd1024);
      check("t4_sweep_bad", 32'(bad), 'd0);
      check("t4_done_early", 32'(done_n), 'd0);
      @(negedge clk);
      check("t4_busy_end", 32'(clr_busy), 'h0);
      check("t4_done", 32'(clr_done), 'h1);
      check("t4_post_gnt", 32'(req_ready), 'h1);
      check("t4_post_ren", 32'({bram_ren, bram_addr}), 32'({1'b1, 14'd1023}));
      next_cyc();
      clear_reqs();
      @(negedge clk);
      check("t4_done_once", 32'(clr_done), 'h0);
      check("t4_rsp_vld", 32'(rsp_valid), 'h1);
      check("t4_rsp_zero", 32'(rsp_rdata), 'h0);

      // RD_LAT=2 instance: latency, then reset discards an in-flight read
      next_cyc();
      req_valid2 = 4'b0010;
      @(negedge clk);
      check("t5_gnt1", 32'(req_ready2), 'h2);
      check("t5_ren", 32'(bram_ren2), 'h1);
      next_cyc();
      req_valid2 = 4'b0000;
      @(negedge clk);
      check("t5_lat_early", 32'(rsp_valid2), 'h0);
      next_cyc();
      @(negedge clk);
      check("t5_lat2_rsp", 32'(rsp_valid2), 'h2);
      check("t5_lat2_data", 32'(rsp_rdata2), 'h155);
      next_cyc();
      req_valid2 = 4'b0001;
      @(negedge clk);
      check("t5_gnt0", 32'(req_ready2), 'h1);
      next_cyc();
      req_valid2 = 4'b0000;
      rst2_n = 1'b0;
      @(negedge clk);
      check("t5_rst_outs", 32'({req_ready2, rsp_valid2, bram_ren2, bram_wen2,
                                clr_busy2, clr_done2}), 'h0);
      check("t5_rst_bus", 32'(bram_addr2 | 14'(rsp_rdata2)), 'h0);
      next_cyc();
      rst2_n = 1'b1;
      @(negedge clk);
      check("t5_discard", 32'(rsp_valid2), 'h0);
      next_cyc();
      req_valid2 = 4'b1111;
      @(negedge clk);
      check("t5_ptr_reset", 32'(req_ready2), 'h1);
      check("t5_no_rsp", 32'(rsp_valid2), 'h0);
      next_cyc();
      req_valid2 = 4'b0000;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
